// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch unit: bus widths, enable
// levels, FSM state encoding and the prefetch FIFO entry layout.
package inst_fetch_unit_pkg;

    localparam int          InstAddrW      = 32;
    localparam int          InstDataW      = 32;
    localparam logic        RstEnable      = 1'b1;
    localparam logic        ChipEnable     = 1'b1;
    localparam logic        ChipDisable    = 1'b0;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;
    localparam int          FetchFifoDepth = 2;

    typedef enum logic [1:0] {
        IF_RST   = 2'd0,
        IF_FETCH = 2'd1,
        IF_HOLD  = 2'd2
    } if_state_e;

    typedef struct packed {
        logic                 adel;
        logic [InstAddrW-1:0] pc;
        logic [InstDataW-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Prefetch FIFO between ROM fetch and ID. A clear with keep_head set retains the
// word pushed in the same cycle (the branch delay slot fetched into an empty FIFO).
module inst_fetch_unit_fetch_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH = FetchFifoDepth
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic         keep_head,
    input  fetch_entry_t push_data,
    output logic         full,
    output logic         afull,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_cnt;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_cnt == CW'(DEPTH));
    assign afull     = (r_cnt == CW'(DEPTH - 1));
    assign empty     = (r_cnt == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign head      = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (clear) begin
            r_rd <= '0;
            if (keep_head && w_do_push) begin
                r_mem[0] <= push_data;
                r_wr     <= PW'(1);
                r_cnt    <= CW'(1);
            end else begin
                r_wr  <= '0;
                r_cnt <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= push_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_do_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, drives the combinational ROM and feeds IF/ID
// through a small prefetch FIFO. Optional misaligned-fetch trap: FETCH_ADDR_CHECK_EN.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = FetchFifoDepth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic [InstAddrW-1:0] new_pc_i,
    input  logic                 branch_flag_i,
    input  logic [InstAddrW-1:0] branch_target_i,
    output logic                 rom_ce_o,
    output logic [InstAddrW-1:0] rom_addr_o,
    input  logic [InstDataW-1:0] rom_inst_i,
    output logic                 if_valid_o,
    output logic [InstAddrW-1:0] if_pc_o,
    output logic [InstDataW-1:0] if_inst_o,
    output logic                 if_adel_o
);

    if_state_e            r_state;
    if_state_e            w_next_state;
    logic [InstAddrW-1:0] r_fetch_pc;
    logic                 r_stop;
    logic                 w_fetching;
    logic                 w_misalign;
    logic                 w_pop;
    logic                 w_branch;
    logic                 w_push;
    logic                 w_clear;
    logic                 w_full;
    logic                 w_afull;
    logic                 w_empty;
    logic                 w_will_full;
    fetch_entry_t         w_push_data;
    fetch_entry_t         w_head;

`ifdef FETCH_ADDR_CHECK_EN
    assign w_misalign = (r_fetch_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fetching = (r_state == IF_FETCH);
    assign w_pop      = !w_empty && !stall_i;
    assign w_branch   = branch_flag_i && !stall_i && !flush_i;
    // On a branch only an empty FIFO takes this cycle's word: it is the delay slot.
    assign w_push     = w_fetching && !flush_i && (!w_branch || w_empty);
    assign w_clear    = flush_i || w_branch;
    assign w_will_full = (w_afull && w_push && !w_pop) || (w_full && !(w_pop && !w_push));

    always_comb begin
        w_push_data.adel = w_misalign;
        w_push_data.pc   = r_fetch_pc;
        w_push_data.inst = w_misalign ? ZeroWord : rom_inst_i;
    end

    inst_fetch_unit_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .clear     (w_clear),
        .keep_head (w_branch),
        .push_data (w_push_data),
        .full      (w_full),
        .afull     (w_afull),
        .empty     (w_empty),
        .head      (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) r_state <= IF_RST;
        else                  r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (flush_i || w_branch) begin
            w_next_state = IF_FETCH;
        end else begin
            case (r_state)
                IF_RST:   w_next_state = IF_FETCH;
                IF_FETCH: if (w_will_full || w_misalign) w_next_state = IF_HOLD;
                IF_HOLD:  if (w_pop && !r_stop) w_next_state = IF_FETCH;
                default:  w_next_state = IF_RST;
            endcase
        end
    end

    always_comb begin
        rom_ce_o   = ChipDisable;
        rom_addr_o = ZeroWord;
        if (w_fetching && !w_misalign) begin
            rom_ce_o   = ChipEnable;
            rom_addr_o = r_fetch_pc;
        end
    end

    // A trapped fetch leaves the PC in place and parks until a redirect.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_fetch_pc <= RESET_PC;
            r_stop     <= 1'b0;
        end else if (flush_i) begin
            r_fetch_pc <= new_pc_i;
            r_stop     <= 1'b0;
        end else if (w_branch) begin
            r_fetch_pc <= branch_target_i;
            r_stop     <= 1'b0;
        end else if (w_push) begin
            if (w_misalign) r_stop     <= 1'b1;
            else            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    assign if_valid_o = !w_empty;
    assign if_pc_o    = if_valid_o ? w_head.pc   : ZeroWord;
    assign if_inst_o  = if_valid_o ? w_head.inst : ZeroWord;

`ifdef FETCH_ADDR_CHECK_EN
    assign if_adel_o = if_valid_o && w_head.adel;
`else
    logic w_unused_adel;
    assign w_unused_adel = w_head.adel;
    assign if_adel_o     = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked against an architectural next-PC model.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] new_pc_i = 32'h0;
    logic [31:0] branch_target_i = 32'h0;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_adel_o;

    int errors = 0;
    int checks = 0;

`ifdef FETCH_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .if_adel_o       (if_adel_o)
    );

    // Word-indexed ROM contents; word 0 is 32'h3401_1100.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return ({2'b00, a[31:2]} * 32'h9E37_79B1) ^ 32'h3401_1100;
    endfunction

    assign rom_inst_i = rom_word(rom_addr_o);

    function automatic logic exp_adel(input logic [31:0] pc);
        return ADDR_CHECK && (pc[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        return exp_adel(pc) ? 32'h0 : rom_word(pc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural model: the next instruction ID must receive, and a pending
    // branch target that replaces it once the delay slot has been consumed.
    logic [31:0] m_exp = 32'h0;
    logic [31:0] m_tgt = 32'h0;
    bit          m_pend = 1'b0;
    bit          m_prev_flush = 1'b0;
    bit          m_prev_rst = 1'b0;
    int          m_since = 0;
    int          m_pops = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_exp        = 32'h0;
            m_pend       = 1'b0;
            m_prev_flush = 1'b0;
            m_prev_rst   = 1'b1;
            m_since      = 0;
        end else begin
            m_since++;
            if (m_prev_rst) begin
                chk("post_rst_valid", if_valid_o, 1'b0);
                chk("post_rst_ce", rom_ce_o, 1'b0);
            end
            if (m_prev_flush) chk("flush_bubble", if_valid_o, 1'b0);
            if (if_valid_o) begin
                chk("head_inst", if_inst_o, exp_inst(if_pc_o));
                chk("head_adel", if_adel_o, exp_adel(if_pc_o));
            end
            if (flush_i) begin
                m_exp  = new_pc_i;
                m_pend = 1'b0;
            end else begin
                if (branch_flag_i && !stall_i) begin
                    m_pend = 1'b1;
                    m_tgt  = branch_target_i;
                end
                if (if_valid_o && !stall_i) begin
                    chk("pop_pc", if_pc_o, m_exp);
                    m_pops++;
                    m_exp  = m_pend ? m_tgt : m_exp + 32'd4;
                    m_pend = 1'b0;
                end
            end
            m_prev_flush = flush_i;
            m_prev_rst   = 1'b0;
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_ce", rom_ce_o, 1'b0);
        chk("rst_addr", rom_addr_o, 32'h0);
        chk("rst_valid", if_valid_o, 1'b0);
        chk("rst_pc", if_pc_o, 32'h0);
        chk("rst_inst", if_inst_o, 32'h0);
        chk("rst_adel", if_adel_o, 1'b0);

        rst = 1'b0;
        chk("rst_cycle_ce", rom_ce_o, 1'b0);
        tick();
        chk("first_ce", rom_ce_o, 1'b1);
        chk("first_addr", rom_addr_o, 32'h0);
        chk("first_valid", if_valid_o, 1'b0);
        tick();
        chk("c2_valid", if_valid_o, 1'b1);
        chk("c2_pc", if_pc_o, 32'h0);
        chk("c2_inst", if_inst_o, 32'h3401_1100);
        tick();
        chk("c3_pc", if_pc_o, 32'h4);
        tick();
        chk("c4_pc", if_pc_o, 32'h8);

        stall_i = 1'b1;
        tick();
        chk("stall_pc", if_pc_o, 32'h8);
        chk("stall_ce", rom_ce_o, 1'b0);
        repeat (4) tick();
        chk("stall_end_pc", if_pc_o, 32'h8);
        chk("stall_end_ce", rom_ce_o, 1'b0);
        stall_i = 1'b0;
        tick();
        chk("release_pc0", if_pc_o, 32'hC);
        tick();
        chk("release_pc1", if_pc_o, 32'h10);

        branch_flag_i   = 1'b1;
        branch_target_i = 32'h100;
        tick();
        branch_flag_i = 1'b0;
        chk("br_bubble", if_valid_o, 1'b0);
        tick();
        chk("br_target_pc", if_pc_o, 32'h100);

        stall_i = 1'b1;
        tick();
        tick();
        chk("full_ce", rom_ce_o, 1'b0);
        chk("full_pc", if_pc_o, 32'h100);
        stall_i         = 1'b0;
        flush_i         = 1'b1;
        new_pc_i        = 32'h20;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h300;
        tick();
        flush_i       = 1'b0;
        branch_flag_i = 1'b0;
        chk("flush_valid", if_valid_o, 1'b0);
        tick();
        chk("flush_pc", if_pc_o, 32'h20);

        flush_i  = 1'b1;
        new_pc_i = 32'h40;
        tick();
        flush_i         = 1'b0;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h200;
        tick();
        branch_flag_i = 1'b0;
        chk("empty_br_slot", if_pc_o, 32'h40);
        tick();
        chk("empty_br_target", if_pc_o, 32'h200);

        stall_i  = 1'b1;
        flush_i  = 1'b1;
        new_pc_i = 32'h22;
        tick();
        flush_i = 1'b0;
        chk("mis_ce", rom_ce_o, !ADDR_CHECK);
        tick();
        chk("mis_pc", if_pc_o, 32'h22);
        chk("mis_adel", if_adel_o, ADDR_CHECK);
        chk("mis_inst", if_inst_o, ADDR_CHECK ? 32'h0 : rom_word(32'h20));

        flush_i  = 1'b1;
        new_pc_i = 32'h1000;
        stall_i  = 1'b0;
        tick();
        flush_i = 1'b0;

        for (int i = 0; i < 800; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            stall_i         = ($urandom_range(0, 2) == 0);
            flush_i         = ($urandom_range(0, 24) == 0);
            new_pc_i        = {14'h0, 16'($urandom_range(0, 16'hFFFF)), 2'b00};
            branch_target_i = {14'h0, 16'($urandom_range(0, 16'hFFFF)), 2'b00};
            branch_flag_i   = ($urandom_range(0, 5) == 0) && (stall_i || (m_since >= 1 && !m_pend));
            tick();
        end
        rst           = 1'b0;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        branch_flag_i = 1'b0;
        repeat (4) tick();
        chk("liveness", (m_pops > 150), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
